// File: rtl/ui_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ui_pkg
// Description : Shared types and constants for the turbo-speed overlay path.
// Revision    : 1.0 - initial release
// ============================================================================
package ui_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        FADE = 2'd2
    } ui_state_t;

    localparam int ALPHA_W   = 4;
    localparam int ALPHA_MAX = 15;

endpackage : ui_pkg
`default_nettype wire

// File: rtl/ui_alpha_blend.sv
`default_nettype none
// ============================================================================
// Module      : ui_alpha_blend
// Description : Combinational per-channel blend out = (fg*a + bg*(16-a)) >> 4.
// Revision    : 1.0 - initial release
// ============================================================================
module ui_alpha_blend
    import ui_pkg::*;
(
    input  rgb_t               fg,
    input  rgb_t               bg,
    input  logic [ALPHA_W-1:0] alpha,
    output rgb_t               blend
);

    logic [23:0] w_fg;
    logic [23:0] w_bg;
    logic [23:0] w_out;

    assign w_fg  = fg;
    assign w_bg  = bg;
    assign blend = w_out;

    // 255*15 + 255*1 = 4080, so 12 bits never overflow
    generate
        for (genvar i = 0; i < 3; i++) begin : g_chan
            logic [11:0] w_mix;
            assign w_mix = (12'(w_fg[i*8 +: 8]) * 12'(alpha))
                         + (12'(w_bg[i*8 +: 8]) * (12'd16 - 12'(alpha)));
            assign w_out[i*8 +: 8] = w_mix[11:4];
        end
    endgenerate

endmodule : ui_alpha_blend
`default_nettype wire

// File: rtl/ui_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ui_overlay_ctrl
// Description : Turbo-speed overlay visibility FSM and compositor.
//               Define UI_FADE_EN to enable the alpha fade-out stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ui_overlay_ctrl
    import ui_pkg::*;
#(
    parameter int SHOW_FRAMES = 120,
    parameter int FADE_FRAMES = 16,
    parameter int DIM_SHIFT   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [2:0]  turbo_speed,
    input  logic        show_req,
    input  logic        de_in,
    input  logic [23:0] cam_rgb,
    input  logic        ui_active,
    input  logic [23:0] ui_rgb,
    output logic        de_out,
    output logic [23:0] rgb_out,
    output logic        overlay_visible
);

    localparam logic [7:0] c_show_load = 8'(SHOW_FRAMES);
`ifdef UI_FADE_EN
    localparam logic [7:0] c_fade_last = 8'(FADE_FRAMES / 16 - 1);
`endif

    ui_state_t   r_state;
    ui_state_t   w_state_n;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  w_frame_cnt_n;
    logic        r_primed;
    logic [2:0]  r_prev_speed;
    logic        w_trigger;
    logic        w_vis;
    logic [23:0] w_bg;
    logic [23:0] w_fg;
    logic [23:0] w_pix;
    logic        r_de;
    logic [23:0] r_rgb;
    logic        r_vis;
`ifdef UI_FADE_EN
    logic [ALPHA_W-1:0] r_alpha;
    logic [ALPHA_W-1:0] w_alpha_n;
    rgb_t               w_blend;
`endif

    assign w_trigger = show_req || (r_primed && (turbo_speed != r_prev_speed));

    always_comb begin
        w_state_n     = r_state;
        w_frame_cnt_n = r_frame_cnt;
`ifdef UI_FADE_EN
        w_alpha_n     = r_alpha;
`endif
        // A trigger always wins over frame counting in the same cycle
        if (w_trigger) begin
            w_state_n     = SHOW;
            w_frame_cnt_n = c_show_load;
`ifdef UI_FADE_EN
            w_alpha_n     = ALPHA_W'(ALPHA_MAX);
`endif
        end else begin
            case (r_state)
                SHOW: begin
                    if (frame_start) begin
                        if (r_frame_cnt == 8'd1) begin
`ifdef UI_FADE_EN
                            w_state_n = FADE;
`else
                            w_state_n = IDLE;
`endif
                            w_frame_cnt_n = 8'd0;
                        end else begin
                            w_frame_cnt_n = r_frame_cnt - 8'd1;
                        end
                    end
                end
                FADE: begin
`ifdef UI_FADE_EN
                    if (frame_start) begin
                        if (r_frame_cnt == c_fade_last) begin
                            w_frame_cnt_n = 8'd0;
                            if (r_alpha == ALPHA_W'(1)) begin
                                w_state_n = IDLE;
                                w_alpha_n = '0;
                            end else begin
                                w_alpha_n = r_alpha - ALPHA_W'(1);
                            end
                        end else begin
                            w_frame_cnt_n = r_frame_cnt + 8'd1;
                        end
                    end
`else
                    w_state_n = IDLE;
`endif
                end
                default: ;
            endcase
        end
    end

    // Composite against the next state so pixels and overlay_visible move together
    assign w_vis = (w_state_n != IDLE);
    assign w_bg  = {cam_rgb[23:16] >> DIM_SHIFT, cam_rgb[15:8] >> DIM_SHIFT, cam_rgb[7:0] >> DIM_SHIFT};
    assign w_fg  = (ui_rgb != 24'd0) ? ui_rgb : w_bg;

`ifdef UI_FADE_EN
    ui_alpha_blend u_blend (
        .fg    (rgb_t'(w_fg)),
        .bg    (rgb_t'(cam_rgb)),
        .alpha (w_alpha_n),
        .blend (w_blend)
    );
`endif

    always_comb begin
        w_pix = cam_rgb;
        if (!de_in) begin
            w_pix = 24'd0;
        end else if (w_vis && ui_active) begin
`ifdef UI_FADE_EN
            w_pix = (w_state_n == FADE) ? 24'(w_blend) : w_fg;
`else
            w_pix = w_fg;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_frame_cnt  <= 8'd0;
            r_primed     <= 1'b0;
            r_prev_speed <= 3'd0;
            r_de         <= 1'b0;
            r_rgb        <= 24'd0;
            r_vis        <= 1'b0;
`ifdef UI_FADE_EN
            r_alpha      <= '0;
`endif
        end else begin
            r_state      <= w_state_n;
            r_frame_cnt  <= w_frame_cnt_n;
            r_primed     <= 1'b1;
            r_prev_speed <= turbo_speed;
            r_de         <= de_in;
            r_rgb        <= w_pix;
            r_vis        <= w_vis;
`ifdef UI_FADE_EN
            r_alpha      <= w_alpha_n;
`endif
        end
    end

    assign de_out          = r_de;
    assign rgb_out         = r_rgb;
    assign overlay_visible = r_vis;

endmodule : ui_overlay_ctrl
`default_nettype wire

// File: doc/ui_overlay_ctrl.md
Name: ui_overlay_ctrl

Overview:
- Sits directly downstream of the UI text renderer, in the video path before the scaler/output.
- Decides when the "Turbo Speed" overlay is visible: on a speed change or an explicit request, it shows for a fixed number of frames, optionally fades out, then hides.
- Composites the renderer's text pixels and its active band over the camera pixel stream, dimming the camera image behind the band.

Parameters:
- SHOW_FRAMES, 120, frames the overlay stays fully opaque after a trigger (1..255).
- FADE_FRAMES, 16, frames per fade sequence; alpha steps down 15→0, one step per FADE_FRAMES/16 frames (power of 2, 16..256).
- DIM_SHIFT, 2, right-shift applied to camera channels inside the active band while visible (0..7).

Ports:
- clk, in, 1: pixel clock.
- reset_n, in, 1: asynchronous active-low reset.
- frame_start, in, 1: one-cycle pulse at the start of each frame.
- turbo_speed, in, 3: current speed setting; the same value is fed to the renderer.
- show_req, in, 1: one-cycle pulse forcing the overlay to show (e.g. a button).
- de_in, in, 1: camera pixel valid.
- cam_rgb, in, 24: camera pixel {R,G,B}.
- ui_active, in, 1: renderer band flag, aligned with cam_rgb.
- ui_rgb, in, 24: renderer text pixel, aligned with cam_rgb.
- de_out, out, 1: de_in delayed one cycle.
- rgb_out, out, 24: composited pixel.
- overlay_visible, out, 1: high in SHOW or FADE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, frame_cnt=0, alpha=0, primed=0, prev_speed=0.
  - de_out=0, rgb_out=0, overlay_visible=0.
- Speed-change detection:
  - First clock after reset: prev_speed<=turbo_speed and primed<=1, with no trigger.
  - After that, trigger = primed && (turbo_speed != prev_speed), or show_req.
  - prev_speed updates every cycle.
- State machine (all registered):
  - IDLE: on trigger → SHOW, frame_cnt<=SHOW_FRAMES, alpha<=15.
  - SHOW: on frame_start, frame_cnt decrements. When frame_cnt==1 and frame_start arrives → FADE (UI_FADE_EN defined) or IDLE (undefined). frame_cnt<=0 in either case.
  - FADE: frame_cnt counts frame_start pulses modulo FADE_FRAMES/16, and alpha decrements at each wrap. On alpha==1 with a step → IDLE, alpha<=0.
  - A trigger in SHOW or FADE restarts SHOW with a full reload and alpha<=15.
  - Trigger and frame_start in the same cycle: trigger wins; the frame is not counted.
- Compositing:
  - 1-cycle registered latency; de_out, rgb_out and overlay_visible all change together.
  - In IDLE, or when ui_active=0: rgb_out = cam_rgb.
  - When visible and ui_active=1: bg = each channel >> DIM_SHIFT.
    - SHOW: rgb_out = ui_rgb if ui_rgb != 0, else bg.
    - FADE, per channel: out = (fg*alpha + c*(16-alpha)) >> 4. fg is the ui_rgb channel where ui_rgb != 0, otherwise bg. c is the raw cam channel. Intermediate width is 12 bits; no overflow is possible.
  - When de_in=0: rgb_out=0.
- frame_start carries no pixel meaning; it is not gated by de_in.

Optional Feature:
- Macro: UI_FADE_EN.
- Defined: the FADE state and blend multiplier exist as described.
- Undefined: there is no FADE state and no multiplier; SHOW exits directly to IDLE and alpha is a constant 15.

Decomposition:
- Package ui_pkg holds:
  - the rgb_t typedef (24-bit packed {r,g,b}).
  - the ui_state_t enum {IDLE, SHOW, FADE}.
  - ALPHA_MAX=15 and ALPHA_W=4.
- One sub-module, ui_alpha_blend: a combinational per-channel blend of 3 channels, taking fg, bg and alpha. It is instantiated only under UI_FADE_EN.

Test Plan:
- Reset with turbo_speed=3, then run 5 frames → no trigger; overlay_visible=0; rgb_out equals cam_rgb delayed 1 cycle.
- Change turbo_speed 0→2 mid-frame → overlay_visible=1 on the next cycle. With ui_active=1, ui_rgb=0 and cam=0x80C040, rgb_out=0x203010. With ui_rgb=0xFFFFFF, rgb_out=0xFFFFFF.
- SHOW_FRAMES=3 with UI_FADE_EN undefined, trigger then 3 frame_start pulses → IDLE on the cycle after the 3rd pulse.
- UI_FADE_EN, FADE_FRAMES=16, cam=0x000000, ui_rgb=0xFFFFFF:
  - FADE step at alpha=8 → 0x7F7F7F.
  - IDLE after 15 more frames following SHOW expiry.
- Mid-FADE: show_req coincident with frame_start → SHOW, frame_cnt=SHOW_FRAMES, alpha=15; the frame is not counted.
- Assert reset_n mid-SHOW → all outputs 0 immediately (asynchronous). After release, no spurious trigger even though turbo_speed is nonzero.
